calc2_req_port: RTL and testbench
=================================

# calc2_req_port

Request issuer for one calc2 input port. It accepts operation requests from the test/stimulus side over a valid/ready handshake and buffers them in a small FIFO. It allocates a free 2-bit tag per request and serialises each request into the calc2 two-cycle port protocol. On the response side it matches calc2 port responses back to the caller's request id. One instance sits directly upstream of each of the four calc2 request ports.

## Interface
- DEPTH, 4, input FIFO entries (power of two, ≥2)
- ID_W, 8, caller request-id width
- c_clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  request offered
- in_ready  out  1  FIFO not full
- in_cmd  in  4  1=add, 2=sub, 5=shl, 6=shr
- in_op1, in_op2  in  32  operands
- in_id  in  ID_W  caller id, returned with response
- req_cmd_out  out  4  to calc2 reqN_cmd_in
- req_data_out  out  32  to calc2 reqN_data_in
- req_tag_out  out  2  to calc2 reqN_tag_in
- port_resp_in  in  2  from calc2 out_respN (0=none, 1=ok, 2=overflow/invalid)
- port_data_in  in  32  from calc2 out_dataN
- port_tag_in  in  2  from calc2 out_tagN
- rsp_valid  out  1  one-cycle response strobe
- rsp_resp  out  2  response code
- rsp_data  out  32  result
- rsp_id  out  ID_W  id of completed request
- outstanding  out  3  tags in flight (0..4)
- err_tag  out  1  sticky: response arrived with a tag not in flight

## Operation
- FIFO: push when in_valid && in_ready; in_ready = !full. A push and a pop in the same cycle when full is not allowed (in_ready low). A push and a pop in the same cycle when non-empty are both performed.
- Tag table: 4 entries {busy, id}. Allocation always picks the lowest free tag.
- FSM states IDLE, CMD, DATA2. All port outputs are registered.
  - IDLE: drive cmd=0, data=0, tag=0. If FIFO is non-empty and a tag is free, pop the FIFO head, allocate the tag and go to CMD.
  - CMD: drive cmd=in_cmd, data=op1, tag=allocated tag. Always go to DATA2.
  - DATA2: drive cmd=0, data=op2, tag=0. If the next request is poppable and a tag is free, go straight to CMD; else go to IDLE.
- Illegal cmd (not 1/2/5/6) at the FIFO head: popped without issuing and without allocating a tag. Produces a local response rsp_resp=2, rsp_data=0, rsp_id=that id, in the cycle after the pop. The FSM stays in IDLE for that cycle.
- Response capture: port_resp_in≠0 with a busy tag frees the tag and registers rsp_* next cycle. No backpressure on rsp_*.
- port_resp_in≠0 with a non-busy tag: dropped, err_tag set. err_tag clears only on reset.
- Local and calc2 response in the same cycle: the calc2 response wins. The local response is held one cycle, and further pops are stalled until it is emitted.
- Tag freed and allocation requested in the same cycle: the freed tag is not visible until the next cycle.
- outstanding = number of busy tags, updated on the same edges as the table.

## Timing
- Reset (async assert, sync deassert assumed by environment) forces:
  - FSM=IDLE, FIFO empty, table clear
  - all req_*_out=0, rsp_valid=0, rsp_*=0, outstanding=0, err_tag=0, in_ready=1
- Latency from push at edge N into an empty FIFO with a free tag:
  - pop/allocate at N+1
  - CMD values visible after N+2
  - DATA2 values visible after N+3
- Back-to-back issue rate: one request per 2 cycles.
- Response latency: rsp_valid is asserted the cycle after port_resp_in≠0.
- Reset mid-operation: everything is dropped. calc2 must be reset together; stale calc2 responses arriving after reset set err_tag.

## Test plan
- Reset, then push add(cmd 1, 0x5, 0x3, id 0x11).
  - Ports show cmd 1/data 5/tag 0, then cmd 0/data 3/tag 0.
  - Model resp 1/data 8/tag 0 → rsp_valid with rsp_data 8, rsp_id 0x11; outstanding 1→0.
- Push 5 requests with no responses returned.
  - Tags issued in order 0,1,2,3; the fifth waits in the FIFO and outstanding stays 4.
  - Return tag 2 → the fifth issues with tag 2 one cycle later.
- Fill FIFO (DEPTH=4) while the FSM is blocked → in_ready=0. One pop → in_ready=1 the next cycle.
- Push cmd 0x3, id 0x22 → no port activity; rsp_resp 2, rsp_data 0, rsp_id 0x22.
- Model returns resp 1 on tag 3 with nothing in flight → no rsp_valid, err_tag=1, held until reset.
- Assert reset during DATA2 → all outputs are 0 immediately (asynchronous), FIFO empty, and the next request issues with tag 0.

Source files
------------

// File: rtl/calc2_req_port.sv
// calc2_req_port: request issuer for one calc2 input port.
// Buffers caller requests in a small FIFO and gives each one the lowest free
// 2-bit tag. Each request goes out over the two-cycle calc2 port protocol:
// a CMD beat carries cmd/op1/tag, then a DATA2 beat carries op2.
// calc2 responses are matched back to the caller id through the tag table.
// Requests with an illegal command never reach calc2. They are answered
// locally with response code 2.
module calc2_req_port #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 8
) (
    input  logic            c_clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_cmd,
    input  logic [31:0]     in_op1,
    input  logic [31:0]     in_op2,
    input  logic [ID_W-1:0] in_id,
    output logic [3:0]      req_cmd_out,
    output logic [31:0]     req_data_out,
    output logic [1:0]      req_tag_out,
    input  logic [1:0]      port_resp_in,
    input  logic [31:0]     port_data_in,
    input  logic [1:0]      port_tag_in,
    output logic            rsp_valid,
    output logic [1:0]      rsp_resp,
    output logic [31:0]     rsp_data,
    output logic [ID_W-1:0] rsp_id,
    output logic [2:0]      outstanding,
    output logic            err_tag
);
    localparam int AW   = $clog2(DEPTH);
    localparam int EW   = 4 + 32 + 32 + ID_W;
    localparam int NTAG = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA2 = 2'd2
    } state_t;

    // ---------------- input FIFO ----------------
    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [3:0]      head_cmd;
    logic [31:0]     head_op1;
    logic [31:0]     head_op2;
    logic [ID_W-1:0] head_id;
    logic            head_legal;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign {head_cmd, head_op1, head_op2, head_id} = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign head_legal = (head_cmd == 4'd1) || (head_cmd == 4'd2) ||
                        (head_cmd == 4'd5) || (head_cmd == 4'd6);

    // FIFO storage write; contents need no reset because the pointers gate them
    always_ff @(posedge c_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {in_cmd, in_op1, in_op2, in_id};
        end
    end

    // FIFO pointers advance independently on push and pop
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // ---------------- tag table ----------------
    logic [NTAG-1:0] busy_reg;
    logic [NTAG-1:0] busy_next;
    logic [ID_W-1:0] tag_id_reg [NTAG];
    logic            tag_free;
    logic [1:0]      alloc_tag;
    logic            alloc_en;
    logic            port_valid;
    logic            port_hit;
    logic            port_miss;

    assign port_valid = (port_resp_in != 2'd0);
    assign port_hit   = port_valid && busy_reg[port_tag_in];
    assign port_miss  = port_valid && !busy_reg[port_tag_in];

    // Lowest free tag, taken from the registered table so a tag freed this
    // cycle only becomes allocatable on the next one
    always_comb begin
        tag_free  = 1'b0;
        alloc_tag = 2'd0;
        for (int i = NTAG - 1; i >= 0; i--) begin
            if (!busy_reg[i]) begin
                tag_free  = 1'b1;
                alloc_tag = 2'(i);
            end
        end
    end

    // Per-tag busy update: allocation sets the bit and a matched response clears it
    genvar gi;
    generate
        for (gi = 0; gi < NTAG; gi++) begin : g_tag
            assign busy_next[gi] = (alloc_en && alloc_tag == 2'(gi)) ? 1'b1 :
                                   (port_hit && port_tag_in == 2'(gi)) ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    // Tag table register: busy bits and the caller id owning each tag
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy_reg <= '0;
            for (int i = 0; i < NTAG; i++) tag_id_reg[i] <= '0;
        end else begin
            busy_reg <= busy_next;
            if (alloc_en) tag_id_reg[alloc_tag] <= head_id;
        end
    end

    // Count of tags in flight, derived from the registered table
    always_comb begin
        outstanding = 3'd0;
        for (int i = 0; i < NTAG; i++) outstanding = outstanding + 3'(busy_reg[i]);
    end

    // ---------------- issue FSM ----------------
    state_t          state_reg, state_next;
    logic [3:0]      cur_cmd_reg;
    logic [31:0]     cur_op1_reg;
    logic [31:0]     cur_op2_reg;
    logic [1:0]      cur_tag_reg;
    logic [3:0]      req_cmd_reg, req_cmd_next;
    logic [31:0]     req_data_reg, req_data_next;
    logic [1:0]      req_tag_reg, req_tag_next;
    logic            local_pend_reg;
    logic [ID_W-1:0] local_id_reg;
    logic            can_issue;
    logic            can_drop;
    logic            illegal_pop;

    // A pending local response blocks every pop until it has been emitted
    assign can_issue = !fifo_empty && head_legal && tag_free && !local_pend_reg;
    assign can_drop  = !fifo_empty && !head_legal && !local_pend_reg;

    // Next state, pop/allocate decisions and next port-beat values
    always_comb begin
        state_next    = state_reg;
        pop           = 1'b0;
        alloc_en      = 1'b0;
        illegal_pop   = 1'b0;
        req_cmd_next  = 4'd0;
        req_data_next = 32'd0;
        req_tag_next  = 2'd0;
        case (state_reg)
            IDLE: begin
                if (can_issue) begin
                    pop        = 1'b1;
                    alloc_en   = 1'b1;
                    state_next = CMD;
                end else if (can_drop) begin
                    pop         = 1'b1;
                    illegal_pop = 1'b1;
                end
            end
            CMD: begin
                req_cmd_next  = cur_cmd_reg;
                req_data_next = cur_op1_reg;
                req_tag_next  = cur_tag_reg;
                state_next    = DATA2;
            end
            DATA2: begin
                req_data_next = cur_op2_reg;
                if (can_issue) begin
                    pop        = 1'b1;
                    alloc_en   = 1'b1;
                    state_next = CMD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched request being issued and registered port outputs
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cur_cmd_reg  <= 4'd0;
            cur_op1_reg  <= 32'd0;
            cur_op2_reg  <= 32'd0;
            cur_tag_reg  <= 2'd0;
            req_cmd_reg  <= 4'd0;
            req_data_reg <= 32'd0;
            req_tag_reg  <= 2'd0;
        end else begin
            state_reg    <= state_next;
            req_cmd_reg  <= req_cmd_next;
            req_data_reg <= req_data_next;
            req_tag_reg  <= req_tag_next;
            if (alloc_en) begin
                cur_cmd_reg <= head_cmd;
                cur_op1_reg <= head_op1;
                cur_op2_reg <= head_op2;
                cur_tag_reg <= alloc_tag;
            end
        end
    end

    assign req_cmd_out  = req_cmd_reg;
    assign req_data_out = req_data_reg;
    assign req_tag_out  = req_tag_reg;

    // ---------------- response path ----------------
    // calc2 responses take priority; a colliding local response is parked for a cycle
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            rsp_valid      <= 1'b0;
            rsp_resp       <= 2'd0;
            rsp_data       <= 32'd0;
            rsp_id         <= '0;
            local_pend_reg <= 1'b0;
            local_id_reg   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (port_hit) begin
                rsp_valid <= 1'b1;
                rsp_resp  <= port_resp_in;
                rsp_data  <= port_data_in;
                rsp_id    <= tag_id_reg[port_tag_in];
                if (illegal_pop) begin
                    local_pend_reg <= 1'b1;
                    local_id_reg   <= head_id;
                end
            end else if (local_pend_reg) begin
                rsp_valid      <= 1'b1;
                rsp_resp       <= 2'd2;
                rsp_data       <= 32'd0;
                rsp_id         <= local_id_reg;
                local_pend_reg <= 1'b0;
            end else if (illegal_pop) begin
                rsp_valid <= 1'b1;
                rsp_resp  <= 2'd2;
                rsp_data  <= 32'd0;
                rsp_id    <= head_id;
            end
        end
    end

    // Sticky flag for responses that name a tag not currently in flight
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            err_tag <= 1'b0;
        end else if (port_miss) begin
            err_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_calc2_req_port.sv
// tb_calc2_req_port: directed self-checking bench for calc2_req_port.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_calc2_req_port;
    localparam int DEPTH = 4;
    localparam int ID_W  = 8;

    logic            c_clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      in_cmd = 4'd0;
    logic [31:0]     in_op1 = 32'd0;
    logic [31:0]     in_op2 = 32'd0;
    logic [ID_W-1:0] in_id = '0;
    logic [3:0]      req_cmd_out;
    logic [31:0]     req_data_out;
    logic [1:0]      req_tag_out;
    logic [1:0]      port_resp_in = 2'd0;
    logic [31:0]     port_data_in = 32'd0;
    logic [1:0]      port_tag_in = 2'd0;
    logic            rsp_valid;
    logic [1:0]      rsp_resp;
    logic [31:0]     rsp_data;
    logic [ID_W-1:0] rsp_id;
    logic [2:0]      outstanding;
    logic            err_tag;

    int checks   = 0;
    int failures = 0;

    always #5 c_clk = ~c_clk;

    calc2_req_port #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .c_clk(c_clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .in_op1(in_op1), .in_op2(in_op2), .in_id(in_id),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .port_resp_in(port_resp_in), .port_data_in(port_data_in), .port_tag_in(port_tag_in),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .outstanding(outstanding), .err_tag(err_tag)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge c_clk);
    endtask

    task automatic push(input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [7:0] id);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_op1   = op1;
        in_op2   = op2;
        in_id    = id;
        step();
        in_valid = 1'b0;
        $display("push cmd=%0h op1=%0h op2=%0h id=%0h", cmd, op1, op2, id);
    endtask

    task automatic port_rsp(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] tag);
        port_resp_in = resp;
        port_data_in = data;
        port_tag_in  = tag;
        step();
        port_resp_in = 2'd0;
        $display("port response resp=%0d data=%0h tag=%0d", resp, data, tag);
    endtask

    initial begin
        // ---- reset state ----
        repeat (2) step();
        check("rst_cmd",   64'(req_cmd_out),  64'(0));
        check("rst_data",  64'(req_data_out), 64'(0));
        check("rst_tag",   64'(req_tag_out),  64'(0));
        check("rst_rspv",  64'(rsp_valid),    64'(0));
        check("rst_outst", 64'(outstanding),  64'(0));
        check("rst_err",   64'(err_tag),      64'(0));
        check("rst_ready", 64'(in_ready),     64'(1));
        reset = 1'b1;
        step();

        // ---- single add: issue latency and response ----
        push(4'd1, 32'h5, 32'h3, 8'h11);
        check("add_n0_cmd", 64'(req_cmd_out), 64'(0));
        step();
        check("add_n1_cmd",   64'(req_cmd_out), 64'(0));
        check("add_n1_outst", 64'(outstanding), 64'(1));
        step();
        check("add_cmd_cmd",  64'(req_cmd_out),  64'(1));
        check("add_cmd_data", 64'(req_data_out), 64'(5));
        check("add_cmd_tag",  64'(req_tag_out),  64'(0));
        step();
        check("add_d2_cmd",  64'(req_cmd_out),  64'(0));
        check("add_d2_data", 64'(req_data_out), 64'(3));
        check("add_d2_tag",  64'(req_tag_out),  64'(0));
        port_rsp(2'd1, 32'd8, 2'd0);
        check("add_rspv",  64'(rsp_valid),   64'(1));
        check("add_resp",  64'(rsp_resp),    64'(1));
        check("add_rdata", 64'(rsp_data),    64'(8));
        check("add_rid",   64'(rsp_id),      64'(8'h11));
        check("add_outst", 64'(outstanding), 64'(0));
        step();
        check("add_rspv_low", 64'(rsp_valid), 64'(0));

        // ---- illegal command answered locally ----
        push(4'd3, 32'h1234, 32'h5678, 8'h22);
        check("ill_n0_rspv", 64'(rsp_valid), 64'(0));
        step();
        check("ill_rspv",  64'(rsp_valid),   64'(1));
        check("ill_resp",  64'(rsp_resp),    64'(2));
        check("ill_rdata", 64'(rsp_data),    64'(0));
        check("ill_rid",   64'(rsp_id),      64'(8'h22));
        check("ill_cmd",   64'(req_cmd_out), 64'(0));
        check("ill_outst", 64'(outstanding), 64'(0));
        step();
        check("ill_rspv_low", 64'(rsp_valid),   64'(0));
        check("ill_cmd2",     64'(req_cmd_out), 64'(0));

        // ---- local response colliding with a calc2 response ----
        push(4'd2, 32'd20, 32'd6, 8'h60);
        repeat (3) step();
        check("cf_d2_data", 64'(req_data_out), 64'(6));
        in_valid = 1'b1; in_cmd = 4'h9; in_op1 = 32'd1; in_op2 = 32'd1; in_id = 8'h61;
        step();
        $display("push cmd=9 id=61");
        in_cmd = 4'hF; in_id = 8'h62;
        port_resp_in = 2'd1; port_data_in = 32'h77; port_tag_in = 2'd0;
        step();
        $display("push cmd=f id=62 with port response tag=0");
        in_valid = 1'b0; port_resp_in = 2'd0;
        check("cf_a_rspv",  64'(rsp_valid),   64'(1));
        check("cf_a_resp",  64'(rsp_resp),    64'(1));
        check("cf_a_rdata", 64'(rsp_data),    64'(32'h77));
        check("cf_a_rid",   64'(rsp_id),      64'(8'h60));
        check("cf_a_outst", 64'(outstanding), 64'(0));
        step();
        check("cf_b_rspv",  64'(rsp_valid), 64'(1));
        check("cf_b_resp",  64'(rsp_resp),  64'(2));
        check("cf_b_rdata", 64'(rsp_data),  64'(0));
        check("cf_b_rid",   64'(rsp_id),    64'(8'h61));
        step();
        check("cf_c_rspv", 64'(rsp_valid), 64'(1));
        check("cf_c_resp", 64'(rsp_resp),  64'(2));
        check("cf_c_rid",  64'(rsp_id),    64'(8'h62));
        step();
        check("cf_d_rspv", 64'(rsp_valid), 64'(0));

        // ---- response for a tag not in flight ----
        port_rsp(2'd1, 32'h55, 2'd3);
        check("err_rspv",  64'(rsp_valid),   64'(0));
        check("err_flag",  64'(err_tag),     64'(1));
        check("err_outst", 64'(outstanding), 64'(0));
        repeat (3) step();
        check("err_hold", 64'(err_tag), 64'(1));

        // ---- five requests, no responses: tags 0..3 then the fifth waits ----
        for (int t = 0; t < 13; t++) begin
            if (t < 5) begin
                in_valid = 1'b1;
                in_cmd   = 4'd2;
                in_op1   = 32'h100 + 32'(t);
                in_op2   = 32'(t);
                in_id    = 8'(8'h30 + t);
                $display("push cmd=2 op1=%0h op2=%0h id=%0h", in_op1, in_op2, in_id);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (t >= 2 && t <= 8 && (t % 2) == 0) begin
                check("b2b_cmd",  64'(req_cmd_out),  64'(2));
                check("b2b_tag",  64'(req_tag_out),  64'(t / 2 - 1));
                check("b2b_op1",  64'(req_data_out), 64'(32'h100 + 32'(t / 2 - 1)));
            end else if (t >= 3 && t <= 9 && (t % 2) == 1) begin
                check("b2b_d2_cmd", 64'(req_cmd_out),  64'(0));
                check("b2b_op2",    64'(req_data_out), 64'((t - 3) / 2));
            end else if (t >= 10) begin
                check("b2b_blocked", 64'(req_cmd_out), 64'(0));
            end
        end
        in_valid = 1'b0;
        check("b2b_outst", 64'(outstanding), 64'(4));
        check("b2b_ready", 64'(in_ready),    64'(1));

        // ---- fill the FIFO while blocked ----
        push(4'd1, 32'h40, 32'd0, 8'h40);
        push(4'd1, 32'h41, 32'd0, 8'h41);
        check("fill_ready3", 64'(in_ready), 64'(1));
        push(4'd1, 32'h42, 32'd0, 8'h42);
        check("fill_full", 64'(in_ready), 64'(0));
        step();
        check("fill_full2", 64'(in_ready),    64'(0));
        check("fill_cmd",   64'(req_cmd_out), 64'(0));

        // ---- free tag 2: the waiting request takes it one cycle later ----
        port_rsp(2'd1, 32'hAA, 2'd2);
        check("free_rspv",  64'(rsp_valid),   64'(1));
        check("free_rid",   64'(rsp_id),      64'(8'h32));
        check("free_rdata", 64'(rsp_data),    64'(32'hAA));
        check("free_outst", 64'(outstanding), 64'(3));
        check("free_ready", 64'(in_ready),    64'(0));
        step();
        check("pop_ready", 64'(in_ready),    64'(1));
        check("pop_outst", 64'(outstanding), 64'(4));
        check("pop_rspv",  64'(rsp_valid),   64'(0));
        step();
        check("re_cmd",  64'(req_cmd_out),  64'(2));
        check("re_tag",  64'(req_tag_out),  64'(2));
        check("re_data", 64'(req_data_out), 64'(32'h104));
        check("re_err",  64'(err_tag),      64'(1));

        // ---- asynchronous reset while in DATA2 ----
        reset = 1'b0;
        #1;
        check("ar_cmd",   64'(req_cmd_out),  64'(0));
        check("ar_data",  64'(req_data_out), 64'(0));
        check("ar_tag",   64'(req_tag_out),  64'(0));
        check("ar_rspv",  64'(rsp_valid),    64'(0));
        check("ar_rdata", 64'(rsp_data),     64'(0));
        check("ar_rid",   64'(rsp_id),       64'(0));
        check("ar_outst", 64'(outstanding),  64'(0));
        check("ar_err",   64'(err_tag),      64'(0));
        check("ar_ready", 64'(in_ready),     64'(1));
        step();
        reset = 1'b1;
        repeat (3) step();
        check("post_cmd",   64'(req_cmd_out), 64'(0));
        check("post_outst", 64'(outstanding), 64'(0));
        push(4'd1, 32'd7, 32'd9, 8'h50);
        repeat (2) step();
        check("post_icmd",  64'(req_cmd_out),  64'(1));
        check("post_itag",  64'(req_tag_out),  64'(0));
        check("post_idata", 64'(req_data_out), 64'(7));
        step();
        check("post_d2", 64'(req_data_out), 64'(9));
        port_rsp(2'd1, 32'd16, 2'd0);
        check("post_rspv", 64'(rsp_valid), 64'(1));
        check("post_rid",  64'(rsp_id),    64'(8'h50));
        check("post_err",  64'(err_tag),   64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
